// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the flash read master and its helpers.
package flash_pkg;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 16;

    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_REQ       = 4'd1,
        ST_WAIT_DATA = 4'd2,
        ST_SAMPLE_A  = 4'd3,
        ST_SAMPLE_B  = 4'd4,
        ST_DONE      = 4'd5
    } state_e;

endpackage

// File: rtl/flash_word_splitter.sv
// Splits a fetched flash word into the two audio samples in playback order.
module flash_word_splitter
    import flash_pkg::*;
(
    input  logic [DATA_W-1:0]   word,
    input  logic                reverse,
    output logic [SAMPLE_W-1:0] first,
    output logic [SAMPLE_W-1:0] second
);

    // Reverse playback walks the word from the upper half down.
    assign first  = reverse ? word[DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
    assign second = reverse ? word[SAMPLE_W-1:0]      : word[DATA_W-1:SAMPLE_W];

endmodule

// File: rtl/flash_read_master.sv
// Fetches one 32-bit flash word over Avalon-MM and plays it out as two 16-bit
// samples on successive sample strobes, then pulses finish.
module flash_read_master
    import flash_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   address,
    input  logic                reverse,
    input  logic                edge_trigger,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [3:0]          flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic                flash_mem_readdatavalid,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                sample_valid,
    output logic                finish,
    output logic                underrun,
    output logic [3:0]          state
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  rev_q, rev_d;
    logic [DATA_W-1:0]     word_q, word_d;
    logic                  read_q, read_d;
    logic [SAMPLE_W-1:0]   audio_q, audio_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]   first_half, second_half;

    flash_word_splitter u_splitter (
        .word    (word_q),
        .reverse (rev_q),
        .first   (first_half),
        .second  (second_half)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path infers a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        rev_d          = rev_q;
        word_d         = word_q;
        audio_d        = audio_q;
        sample_valid_d = 1'b0;
        underrun_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                underrun_d = edge_trigger;
                if (start) begin
                    addr_d  = address;
                    rev_d   = reverse;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                underrun_d = edge_trigger;
                if (!flash_mem_waitrequest) begin
                    if (flash_mem_readdatavalid) begin
                        word_d  = flash_mem_readdata;
                        state_d = ST_SAMPLE_A;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                underrun_d = edge_trigger;
                if (flash_mem_readdatavalid) begin
                    word_d  = flash_mem_readdata;
                    state_d = ST_SAMPLE_A;
                end
            end
            ST_SAMPLE_A: begin
                if (edge_trigger) begin
                    audio_d        = first_half;
                    sample_valid_d = 1'b1;
                    state_d        = ST_SAMPLE_B;
                end
            end
            ST_SAMPLE_B: begin
                if (edge_trigger) begin
                    audio_d        = second_half;
                    sample_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                underrun_d = edge_trigger;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The read request is live for exactly the cycles spent in REQ.
        read_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            rev_q          <= 1'b0;
            word_q         <= '0;
            read_q         <= 1'b0;
            audio_q        <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q        <= state_d;
            addr_q         <= addr_d;
            rev_q          <= rev_d;
            word_q         <= word_d;
            read_q         <= read_d;
            audio_q        <= audio_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = BYTEENABLE_ALL;
    assign audio_out            = audio_q;
    assign sample_valid         = sample_valid_q;
    assign finish               = (state_q == ST_DONE);
    assign underrun             = underrun_q;
    assign state                = state_q;

endmodule

// File: doc/flash_read_master.md
Name: flash_read_master

Overview:
- Responder side of the address/fetch handshake used by the audio player's address generator.
- Accepts a start pulse with a 23-bit word address, performs one Avalon-MM read from the flash controller, and splits the returned 32-bit word into two 16-bit audio samples.
- Presents each sample on successive sample strobes (edge_trigger), then pulses finish so the address generator advances.

Parameters:
- ADDR_W, 23, flash word address width
- DATA_W, 32, flash read data width
- SAMPLE_W, 16, audio sample width (DATA_W = 2*SAMPLE_W)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle request to fetch the word at address
- address  input  ADDR_W  word address, sampled when start=1 in IDLE
- reverse  input  1  playback direction, sampled with start; 1 = upper half first
- edge_trigger  input  1  one-cycle sample strobe, already synchronous to clk
- flash_mem_read  output  1  Avalon read request
- flash_mem_address  output  ADDR_W  Avalon address
- flash_mem_byteenable  output  4  Avalon byte enables; constant 4'b1111
- flash_mem_waitrequest  input  1  Avalon stall
- flash_mem_readdatavalid  input  1  Avalon read data valid
- flash_mem_readdata  input  DATA_W  Avalon read data
- audio_out  output  SAMPLE_W  current sample, registered
- sample_valid  output  1  one-cycle pulse when audio_out updates
- finish  output  1  one-cycle pulse when both halves have been played
- underrun  output  1  one-cycle pulse when edge_trigger arrives while no sample is ready
- state  output  4  debug state encoding

Behaviour:
- Reset (rst=0, asynchronous) forces IDLE immediately and drives every output to 0 except flash_mem_byteenable. Zeroed outputs: flash_mem_read, flash_mem_address, audio_out, sample_valid, finish, underrun, state. Internal word, address and reverse registers also clear.
- State encoding:
  - IDLE = 0
  - REQ = 1
  - WAIT_DATA = 2
  - SAMPLE_A = 3
  - SAMPLE_B = 4
  - DONE = 5
- IDLE:
  - start=1 latches address and reverse, sets flash_mem_read=1 on the next edge, and moves to REQ.
  - start is ignored in every other state.
- REQ:
  - flash_mem_read and flash_mem_address are held stable while flash_mem_waitrequest=1.
  - On an edge with waitrequest=0, flash_mem_read drops to 0 on that edge.
  - If readdatavalid=1 on the same edge, capture readdata and go to SAMPLE_A. Otherwise go to WAIT_DATA.
- WAIT_DATA: on readdatavalid=1, capture readdata and go to SAMPLE_A. No timeout.
- Half selection:
  - first = reverse ? word[31:16] : word[15:0]
  - second = the other half
- SAMPLE_A: on edge_trigger=1, audio_out <= first, sample_valid pulses for 1 cycle, go to SAMPLE_B.
- SAMPLE_B: on edge_trigger=1, audio_out <= second, sample_valid pulses, go to DONE.
- DONE: finish=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored; the generator issues it after seeing finish.
- underrun pulses when edge_trigger=1 in REQ, WAIT_DATA, DONE or IDLE. In those cases audio_out holds its previous value.
- readdatavalid outside REQ/WAIT_DATA is ignored; stale responses after reset are dropped.
- Latency:
  - start to flash_mem_read=1: 1 cycle.
  - readdatavalid to SAMPLE_A: 1 cycle.
  - edge_trigger to audio_out update: 1 cycle.
- Reset mid-operation deasserts flash_mem_read asynchronously. No read is re-issued.

Decomposition:
- flash_pkg holds:
  - the state typedef, a 4-bit enum with the encodings above
  - ADDR_W, DATA_W and SAMPLE_W constants
  - the BYTEENABLE_ALL constant
- One natural sub-module: flash_word_splitter, combinational half-select on reverse. Optional; inline is acceptable.

Test Plan:
- Basic read:
  - Stimulus: address=23'h000010, reverse=0, start pulse; waitrequest low after 2 cycles; readdatavalid 3 cycles later with data 32'hAAAA5555; two edge_triggers.
  - Response: flash_mem_address=23'h000010 held through the stall; audio_out=16'h5555 then 16'hAAAA; sample_valid pulses twice; single finish pulse.
- Reverse:
  - Stimulus: same transfer with reverse=1.
  - Response: audio_out=16'hAAAA then 16'h5555.
- Same-edge valid:
  - Stimulus: waitrequest=0 and readdatavalid=1 on the first REQ edge.
  - Response: state goes directly 1 to 3 with no WAIT_DATA cycle.
- Underrun:
  - Stimulus: edge_trigger during WAIT_DATA.
  - Response: underrun pulses; audio_out unchanged; state stays 2.
- Ignored start:
  - Stimulus: second start while in SAMPLE_A with address=23'h7FFFFF.
  - Response: no new read; the latched address is unchanged.
- Reset mid-read:
  - Stimulus: rst=0 while in REQ with waitrequest=1.
  - Response: flash_mem_read=0 and state=0 immediately; a later readdatavalid produces no sample_valid.
